// File: rtl/ms_seq_pkg.sv
// Shared types for the mixed-signal pattern sequencer.
// State encoding and the pattern driven while idle.
package ms_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] IDLE_PAT = 8'h00;

endpackage

// File: rtl/ms_sync.sv
// Two-flop synchronizer for the mixed-signal trigger,
// plus a registered copy for rising-edge detection.
module ms_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/ms_seq_ctrl.sv
// Pattern sequencer: plays a programmed list of
// {dwell, pattern} entries onto an 8-bit mixed-signal port.
module ms_seq_ctrl
  import ms_seq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int EW     = 8 + DWELL_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [EW-1:0] cfg_data_i,
  input  logic [AW-1:0] last_idx_i,
  input  logic          loop_i,
  input  logic          trig_en_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          port_ms_i,
  output logic [7:0]    port_ms_o,
  output logic          busy_o,
  output logic [AW-1:0] step_o,
  output logic          done_o,
  output logic          cfg_err_o
);

  state_e state_q, state_d;

  logic [EW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      last_q, last_d;
  logic               loop_q, loop_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [7:0]         pat_q, pat_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic          rise;
  logic          is_idle, is_arm, is_run;
  logic          entry_end, at_last;
  logic          do_load, do_abort, do_trig;
  logic          do_fin, do_adv, do_tick;
  logic [AW-1:0] nxt_idx;
  logic [EW-1:0] ent0, entn;

  ms_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (port_ms_i),
    .rise_o (rise)
  );

  assign is_idle   = (state_q == ST_IDLE);
  assign is_arm    = (state_q == ST_ARM);
  assign is_run    = (state_q == ST_RUN);
  assign entry_end = (cnt_q == '0);
  assign at_last   = (idx_q == last_q);
  assign nxt_idx   = at_last ? '0 : idx_q + 1'b1;
  assign ent0      = mem_q[0];
  assign entn      = mem_q[nxt_idx];

  // Mutually exclusive actions; stop overrides everything.
  assign do_load  = is_idle & start_i & ~stop_i;
  assign do_abort = ~is_idle & stop_i;
  assign do_trig  = is_arm & ~stop_i & rise;
  assign do_fin   = is_run & ~stop_i & entry_end
                  & at_last & ~loop_q;
  assign do_adv   = is_run & ~stop_i & entry_end & ~do_fin;
  assign do_tick  = is_run & ~stop_i & ~entry_end;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (do_load) begin
          state_d = trig_en_i ? ST_ARM : ST_RUN;
        end
      end
      ST_ARM: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_i || do_fin) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    last_d = last_q;
    loop_d = loop_q;
    cnt_d  = cnt_q;
    pat_d  = pat_q;
    done_d = 1'b0;
    err_d  = cfg_we_i & ~is_idle;
    unique case (1'b1)
      do_load: begin
        last_d = last_idx_i;
        loop_d = loop_i;
        idx_d  = '0;
        cnt_d  = ent0[EW-1:8];
        pat_d  = trig_en_i ? IDLE_PAT : ent0[7:0];
      end
      do_abort: begin
        idx_d = '0;
        pat_d = IDLE_PAT;
      end
      do_trig: begin
        cnt_d = ent0[EW-1:8];
        pat_d = ent0[7:0];
      end
      do_fin: begin
        idx_d  = '0;
        pat_d  = IDLE_PAT;
        done_d = 1'b1;
      end
      do_adv: begin
        idx_d = nxt_idx;
        cnt_d = entn[EW-1:8];
        pat_d = entn[7:0];
      end
      do_tick: begin
        cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
      cnt_q  <= '0;
      pat_q  <= IDLE_PAT;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      last_q <= last_d;
      loop_q <= loop_d;
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Entry store is plain flops; writes only land while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (cfg_we_i && is_idle) begin
      mem_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  always_comb begin
    busy_o = ~is_idle;
    step_o = is_idle ? '0 : idx_q;
  end

  assign port_ms_o = pat_q;
  assign done_o    = done_q;
  assign cfg_err_o = err_q;

endmodule

// File: tb/tb_ms_seq_ctrl.sv
// Scoreboard bench for ms_seq_ctrl: stimulus queues the
// expected per-cycle outputs, a negedge monitor checks them.
module tb_ms_seq_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW+7:0] cfg_data;
  logic [AW-1:0] last_idx;
  logic          loop_en;
  logic          trig_en;
  logic          start;
  logic          stop;
  logic          pms_i;
  logic [7:0]    pms_o;
  logic          busy;
  logic [AW-1:0] step;
  logic          done;
  logic          cfg_err;

  ms_seq_ctrl #(.DEPTH(DEPTH), .DWELL_W(DW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_data),
    .last_idx_i (last_idx),
    .loop_i     (loop_en),
    .trig_en_i  (trig_en),
    .start_i    (start),
    .stop_i     (stop),
    .port_ms_i  (pms_i),
    .port_ms_o  (pms_o),
    .busy_o     (busy),
    .step_o     (step),
    .done_o     (done),
    .cfg_err_o  (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    pat;
    logic          done;
    logic          busy;
    logic          err;
    logic [AW-1:0] step;
  } obs_t;

  obs_t  cur;
  obs_t  exp_q[$];
  string nm_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  assign cur = {pms_o, done, busy, cfg_err, step};

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic obs_t mk(logic [7:0] p, logic d,
                              logic b, logic e,
                              logic [AW-1:0] s);
    obs_t o;
    o = {p, d, b, e, s};
    return o;
  endfunction

  task automatic push(string nm, obs_t o);
    exp_q.push_back(o);
    nm_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      obs_t  e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      check(n, 32'(cur), 32'(e));
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
      exp_q.delete();
      nm_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [AW-1:0] a, logic [DW-1:0] dw,
                    logic [7:0] p);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = {dw, p};
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    push("wr_idle", mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
  endtask

  task automatic start_run(logic [AW-1:0] l, logic lp,
                           logic tg);
    last_idx = l;
    loop_en  = lp;
    trig_en  = tg;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Loop run stopped after 10 cycles; optional write mid-run.
  task automatic loop_run(string nm, bit wr_mid);
    logic [7:0]    pa [10];
    logic [AW-1:0] st [10];
    pa = '{8'hA1, 8'hB2, 8'hB2, 8'hB2, 8'hC3,
           8'hC3, 8'hA1, 8'hB2, 8'hB2, 8'hB2};
    st = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2,
           3'd2, 3'd0, 3'd1, 3'd1, 3'd1};
    start_run(3'd2, 1'b1, 1'b0);
    last_idx = 3'd0;
    loop_en  = 1'b0;
    trig_en  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(nm, mk(pa[i], 1'b0, 1'b1,
                  wr_mid && (i == 1), st[i]));
    end
    push({nm, "_stop"}, mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    push({nm, "_idle"}, mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    if (wr_mid) begin
      cfg_we   = 1'b1;
      cfg_addr = 3'd1;
      cfg_data = {8'd0, 8'hFF};
    end
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    last_idx = '0;
    loop_en  = 1'b0;
    trig_en  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    pms_i    = 1'b0;
    #2;
    check("reset_outputs", 32'(cur), 32'(obs_t'(0)));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("post_reset", mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    drain();

    wr(3'd0, 8'd0, 8'hA1);
    wr(3'd1, 8'd2, 8'hB2);
    wr(3'd2, 8'd1, 8'hC3);
    drain();

    start_run(3'd2, 1'b0, 1'b0);
    push("once_a1", mk(8'hA1, 1'b0, 1'b1, 1'b0, 3'd0));
    for (int i = 0; i < 3; i++)
      push("once_b2", mk(8'hB2, 1'b0, 1'b1, 1'b0, 3'd1));
    for (int i = 0; i < 2; i++)
      push("once_c3", mk(8'hC3, 1'b0, 1'b1, 1'b0, 3'd2));
    push("once_done", mk(8'h00, 1'b1, 1'b0, 1'b0, 3'd0));
    push("once_idle", mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    drain();

    loop_run("loop", 1'b0);
    loop_run("wr_run", 1'b1);

    last_idx = 3'd2;
    start    = 1'b1;
    stop     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 3; i++)
      push("start_stop", mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    drain();

    pms_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    start_run(3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      push("arm_hold", mk(8'h00, 1'b0, 1'b1, 1'b0, 3'd0));
    repeat (3) @(posedge clk);
    #1;
    pms_i = 1'b0;
    drain();
    pms_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (pms_o == 8'hA1) found = 1'b1;
    end
    check("trig_latency", 32'(found), 32'd1);
    if (found) begin
      #1;
      push("trig_done", mk(8'h00, 1'b1, 1'b0, 1'b0, 3'd0));
      drain();
    end
    pms_i = 1'b0;

    start_run(3'd2, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'(cur), 32'(obs_t'(0)));
    check("async_rst_pat", 32'(pms_o), 32'h00);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_run(3'd2, 1'b0, 1'b0);
    push("mem_zero", mk(8'h00, 1'b0, 1'b1, 1'b0, 3'd0));
    push("mem_zero", mk(8'h00, 1'b0, 1'b1, 1'b0, 3'd1));
    push("mem_zero", mk(8'h00, 1'b0, 1'b1, 1'b0, 3'd2));
    push("mem_zero_done", mk(8'h00, 1'b1, 1'b0, 1'b0, 3'd0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ms_seq_ctrl.md
MS_SEQ_CTRL -- requirements
Module: ms_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of sequence entries; legal values are powers of two, 2..16.
REQ-002 Parameter DWELL_W, default 8, dwell counter width in bits.
REQ-003 Port clk_i, input, 1, single clock for the block; all logic is on the rising edge.
REQ-004 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 Port cfg_we_i, input, 1, entry write strobe.
REQ-006 Port cfg_addr_i, input, $clog2(DEPTH), entry index to write.
REQ-007 Port cfg_data_i, input, 8+DWELL_W, entry value: [7:0] is the pattern and [8+DWELL_W-1:8] is the dwell.
REQ-008 Port last_idx_i, input, $clog2(DEPTH), index of the final entry; sampled at start.
REQ-009 Port loop_i, input, 1, when 1 the sequence restarts at entry 0 after the last entry; sampled at start.
REQ-010 Port trig_en_i, input, 1, when 1 a run waits for a rising edge on port_ms_i; sampled at start.
REQ-011 Port start_i, input, 1, single-cycle start pulse.
REQ-012 Port stop_i, input, 1, single-cycle abort pulse.
REQ-013 Port port_ms_i, input, 1, asynchronous trigger from the mixed-signal domain.
REQ-014 Port port_ms_o, output, 8, registered pattern to the mixed-signal domain.
REQ-015 Port busy_o, output, 1, high in ARM or RUN.
REQ-016 Port step_o, output, $clog2(DEPTH), current entry index.
REQ-017 Port done_o, output, 1, one-cycle pulse when a non-loop run completes.
REQ-018 Port cfg_err_o, output, 1, one-cycle pulse when a write is rejected.

Function
REQ-019 States SHALL be IDLE, ARM and RUN.
REQ-020 port_ms_i SHALL pass through a 2-flop synchronizer, followed by a registered copy for rising-edge detection.
REQ-021 IDLE, start_i=1, stop_i=0: latch last_idx/loop/trig_en, set idx=0 and load the dwell counter; go to ARM if trig_en_i=1, else RUN.
REQ-022 Without trigger, port_ms_o SHALL equal pattern[0] in the cycle after start_i (1-cycle latency).
REQ-023 ARM SHALL move to RUN on a detected synchronized rising edge; port_ms_o shows pattern[0] at most 4 cycles after port_ms_i rises; a level already high at start SHALL NOT trigger.
REQ-024 RUN holds each entry for dwell+1 cycles; dwell=0 gives 1 cycle, dwell=2^DWELL_W-1 gives 2^DWELL_W cycles.
REQ-025 End of an entry with idx<last_idx SHALL advance idx by 1 and present the next pattern in the next cycle with no gap.
REQ-026 End of an entry with idx==last_idx and loop=1 SHALL wrap idx to 0 with no gap.
REQ-027 End of an entry with idx==last_idx and loop=0 SHALL enter IDLE, set port_ms_o to 8'h00 and pulse done_o, all in the same next cycle.
REQ-028 stop_i in ARM or RUN SHALL enter IDLE next cycle with port_ms_o=0 and no done_o; stop_i wins when asserted together with start_i.
REQ-029 start_i in ARM or RUN SHALL be ignored.
REQ-030 cfg_we_i in IDLE SHALL write the entry; cfg_we_i in ARM or RUN SHALL leave the memory unchanged and pulse cfg_err_o next cycle.
REQ-031 last_idx_i=0 SHALL run entry 0 only.
REQ-032 Changes to last_idx_i, loop_i or trig_en_i during a run SHALL NOT affect that run.
REQ-033 step_o SHALL be 0 in IDLE.

Reset
REQ-034 Reset SHALL drive state to IDLE and all entries, idx, dwell counter and synchronizer flops to 0.
REQ-035 Reset SHALL hold port_ms_o=8'h00 and busy_o, done_o, cfg_err_o at 0.
REQ-036 Reset mid-run SHALL abort immediately, without waiting for a clock edge.

Structure
REQ-037 Package ms_seq_pkg SHALL hold the state enum and the idle-pattern constant 8'h00.
REQ-038 Sub-module ms_sync SHALL implement the 2-flop synchronizer plus edge detect.
REQ-039 The entry memory SHALL be flops, not a macro.

Verification
REQ-040 Entries 0..2 = {dw 0, 8'hA1}, {dw 2, 8'hB2}, {dw 1, 8'hC3}, last_idx=2, no loop, start -> port_ms_o A1 x1, B2 x3, C3 x2, then 00 with done_o pulse.
REQ-041 Same program with loop=1, stop after 10 cycles -> the sequence wraps A1 after C3 without a gap, port_ms_o=00 one cycle after stop, and no done_o.
REQ-042 trig_en=1 with port_ms_i already high at start -> stays in ARM with port_ms_o=00; drop then raise port_ms_i -> A1 appears within 4 cycles.
REQ-043 cfg_we during RUN to entry 1 -> cfg_err_o pulses and the next pass still outputs B2.
REQ-044 start and stop in the same cycle -> remains IDLE; reset asserted mid-RUN -> port_ms_o=00 and busy_o=0 asynchronously, and the memory reads 0.
